// File: rtl/rvc_asap_5pl_cr_mem.sv
// rvc_asap_5pl_cr_mem
// Memory-mapped control-register block for the 5-stage core. It decodes a
// 256-byte window at CR_BASE on the D_MEM request bus. Behind that window are
// the seven-segment and LED drive registers, the synchronized switches, the
// debounced push-buttons with sticky rising-edge events, and a free-running
// cycle counter.
//
// Ports
//   Clock, Rst         : single rising-edge clock, synchronous active-high reset
//   AluOut             : byte address of the request (Q103H)
//   RegRdData2         : write data (Q103H)
//   CtrlDMemByteEn     : per-byte write enables (Q103H)
//   CtrlDMemWrEn       : write request (Q103H)
//   SelDMemWb          : read request (Q103H)
//   CrMemRdDataQ104H   : registered read data, one cycle after the request
//   Button_0/Button_1  : raw asynchronous push-buttons (active-high)
//   Switch             : raw asynchronous slide switches
//   SEG7_0..SEG7_5     : seven-segment drive (active-low, bit 7 = DP)
//   LED                : LED drive (active-high)
//
// Register map (word offsets; unaligned or unlisted offsets read 0 and ignore writes)
//   0x00-0x14 SEG7_0..5 RW, 0x18 LED RW, 0x1C BTN RO, 0x20 SWITCH RO,
//   0x24 BTN_EVENT RW1C, 0x28 CYCLE RO
module rvc_asap_5pl_cr_mem #(
  parameter logic [31:0] CR_BASE         = 32'h00FC_0000,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        Clock,
  input  logic        Rst,
  input  logic [31:0] AluOut,
  input  logic [31:0] RegRdData2,
  input  logic [3:0]  CtrlDMemByteEn,
  input  logic        CtrlDMemWrEn,
  input  logic        SelDMemWb,
  output logic [31:0] CrMemRdDataQ104H,
  input  logic        Button_0,
  input  logic        Button_1,
  input  logic [9:0]  Switch,
  output logic [7:0]  SEG7_0,
  output logic [7:0]  SEG7_1,
  output logic [7:0]  SEG7_2,
  output logic [7:0]  SEG7_3,
  output logic [7:0]  SEG7_4,
  output logic [7:0]  SEG7_5,
  output logic [9:0]  LED
);

  localparam logic [5:0]  IDX_LED  = 6'd6;
  localparam logic [5:0]  IDX_BTN  = 6'd7;
  localparam logic [5:0]  IDX_SW   = 6'd8;
  localparam logic [5:0]  IDX_EVT  = 6'd9;
  localparam logic [5:0]  IDX_CYC  = 6'd10;
  // Debounced level flips on the cycle the counter has reached this value.
  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic       hit;
  logic       aligned;
  logic [5:0] idx;
  logic       wr_go;
  logic       rd_go;

  assign hit     = (AluOut[31:8] == CR_BASE[31:8]);
  assign aligned = (AluOut[1:0] == 2'b00);
  assign idx     = AluOut[7:2];
  assign wr_go   = hit && aligned && CtrlDMemWrEn;
  assign rd_go   = hit && aligned && SelDMemWb;

  // Upper write-data bits and byte enables 3:2 address no stored bits.
  logic unused_wdata;
  assign unused_wdata = ^{RegRdData2[31:10], CtrlDMemByteEn[3:2]};

  // ---------------------------------------------------------------------------
  // Seven-segment registers (byte 0 only, reset to all segments off)
  // ---------------------------------------------------------------------------
  logic [47:0] seg_bus;

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_seg
      logic [7:0] seg_q;
      logic [7:0] seg_d;

      always_comb begin
        seg_d = seg_q;
        if (wr_go && (idx == 6'(gi)) && CtrlDMemByteEn[0]) begin
          seg_d = RegRdData2[7:0];
        end
      end

      always_ff @(posedge Clock) begin
        if (Rst) begin
          seg_q <= 8'hFF;
        end else begin
          seg_q <= seg_d;
        end
      end

      assign seg_bus[gi*8 +: 8] = seg_q;
    end
  endgenerate

  assign SEG7_0 = seg_bus[7:0];
  assign SEG7_1 = seg_bus[15:8];
  assign SEG7_2 = seg_bus[23:16];
  assign SEG7_3 = seg_bus[31:24];
  assign SEG7_4 = seg_bus[39:32];
  assign SEG7_5 = seg_bus[47:40];

  // ---------------------------------------------------------------------------
  // Buttons: 2-flop synchronizer followed by a consecutive-cycle debouncer
  // ---------------------------------------------------------------------------
  logic [1:0] btn_raw;
  logic [1:0] btn_deb;

  assign btn_raw = {Button_1, Button_0};

  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic        sync1_q, sync1_d;
      logic        sync2_q, sync2_d;
      logic        deb_q, deb_d;
      logic [15:0] cnt_q, cnt_d;

      always_comb begin
        sync1_d = btn_raw[gi];
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = '0;
        // Any cycle in agreement restarts the count, so only an unbroken run
        // of DEBOUNCE_CYCLES disagreeing cycles moves the debounced level.
        if (sync2_q != deb_q) begin
          if (cnt_q == CNT_LAST) begin
            deb_d = sync2_q;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end

      always_ff @(posedge Clock) begin
        if (Rst) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
          deb_q   <= 1'b0;
          cnt_q   <= '0;
        end else begin
          sync1_q <= sync1_d;
          sync2_q <= sync2_d;
          deb_q   <= deb_d;
          cnt_q   <= cnt_d;
        end
      end

      assign btn_deb[gi] = deb_q;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Switch synchronizer, LED, button events, cycle counter, read data
  // ---------------------------------------------------------------------------
  logic [9:0]  sw_s1_q, sw_s1_d;
  logic [9:0]  sw_s2_q, sw_s2_d;
  logic [9:0]  led_q, led_d;
  logic [1:0]  evt_q, evt_d;
  logic [1:0]  deb_prev_q, deb_prev_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] rd_q, rd_d;
  logic [1:0]  evt_clr;
  logic [1:0]  btn_rise;

  always_comb begin
    sw_s1_d = Switch;
    sw_s2_d = sw_s1_q;

    led_d = led_q;
    if (wr_go && (idx == IDX_LED)) begin
      if (CtrlDMemByteEn[0]) led_d[7:0] = RegRdData2[7:0];
      if (CtrlDMemByteEn[1]) led_d[9:8] = RegRdData2[9:8];
    end

    // A rising edge arriving in the same cycle as a clear keeps the bit set.
    evt_clr    = (wr_go && (idx == IDX_EVT) && CtrlDMemByteEn[0]) ? RegRdData2[1:0] : 2'b00;
    btn_rise   = btn_deb & ~deb_prev_q;
    deb_prev_d = btn_deb;
    evt_d      = (evt_q & ~evt_clr) | btn_rise;

    cycle_d = cycle_q + 32'd1;

    // Read path samples the current (pre-write) register contents.
    rd_d = '0;
    if (rd_go) begin
      case (idx)
        6'd0:    rd_d = {24'h0, seg_bus[7:0]};
        6'd1:    rd_d = {24'h0, seg_bus[15:8]};
        6'd2:    rd_d = {24'h0, seg_bus[23:16]};
        6'd3:    rd_d = {24'h0, seg_bus[31:24]};
        6'd4:    rd_d = {24'h0, seg_bus[39:32]};
        6'd5:    rd_d = {24'h0, seg_bus[47:40]};
        IDX_LED: rd_d = {22'h0, led_q};
        IDX_BTN: rd_d = {30'h0, btn_deb};
        IDX_SW:  rd_d = {22'h0, sw_s2_q};
        IDX_EVT: rd_d = {30'h0, evt_q};
        IDX_CYC: rd_d = cycle_q;
        default: rd_d = '0;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Rst) begin
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      led_q      <= '0;
      evt_q      <= '0;
      deb_prev_q <= '0;
      cycle_q    <= '0;
      rd_q       <= '0;
    end else begin
      sw_s1_q    <= sw_s1_d;
      sw_s2_q    <= sw_s2_d;
      led_q      <= led_d;
      evt_q      <= evt_d;
      deb_prev_q <= deb_prev_d;
      cycle_q    <= cycle_d;
      rd_q       <= rd_d;
    end
  end

  assign LED              = led_q;
  assign CrMemRdDataQ104H = rd_q;

endmodule

// File: tb/tb_rvc_asap_5pl_cr_mem.sv
// Testbench for rvc_asap_5pl_cr_mem: directed scenarios followed by randomized
// bus, button and switch traffic. Every clock edge is mirrored by a behavioural
// model of the register file, and the DUT's outputs are compared against it.
module tb_rvc_asap_5pl_cr_mem;

  localparam int          D    = 16;
  localparam logic [31:0] BASE = 32'h00FC_0000;

  logic        Clock = 1'b0;
  logic        Rst   = 1'b1;
  logic [31:0] AluOut = '0;
  logic [31:0] RegRdData2 = '0;
  logic [3:0]  CtrlDMemByteEn = '0;
  logic        CtrlDMemWrEn = 1'b0;
  logic        SelDMemWb = 1'b0;
  logic [31:0] CrMemRdDataQ104H;
  logic        Button_0 = 1'b0;
  logic        Button_1 = 1'b0;
  logic [9:0]  Switch = '0;
  logic [7:0]  SEG7_0, SEG7_1, SEG7_2, SEG7_3, SEG7_4, SEG7_5;
  logic [9:0]  LED;

  always #5 Clock = ~Clock;

  rvc_asap_5pl_cr_mem #(
    .CR_BASE         (BASE),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .Clock            (Clock),
    .Rst              (Rst),
    .AluOut           (AluOut),
    .RegRdData2       (RegRdData2),
    .CtrlDMemByteEn   (CtrlDMemByteEn),
    .CtrlDMemWrEn     (CtrlDMemWrEn),
    .SelDMemWb        (SelDMemWb),
    .CrMemRdDataQ104H (CrMemRdDataQ104H),
    .Button_0         (Button_0),
    .Button_1         (Button_1),
    .Switch           (Switch),
    .SEG7_0           (SEG7_0),
    .SEG7_1           (SEG7_1),
    .SEG7_2           (SEG7_2),
    .SEG7_3           (SEG7_3),
    .SEG7_4           (SEG7_4),
    .SEG7_5           (SEG7_5),
    .LED              (LED)
  );

  logic [7:0] dut_seg [6];
  assign dut_seg[0] = SEG7_0;
  assign dut_seg[1] = SEG7_1;
  assign dut_seg[2] = SEG7_2;
  assign dut_seg[3] = SEG7_3;
  assign dut_seg[4] = SEG7_4;
  assign dut_seg[5] = SEG7_5;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [7:0]  m_seg [6];
  logic [9:0]  m_led;
  logic [1:0]  m_hist1, m_hist2;   // raw buttons one and two samples ago
  logic [1:0]  m_deb, m_deb_prev, m_evt;
  int          m_run [2];          // consecutive cycles sync level != debounced
  logic [9:0]  m_sw1, m_sw2;
  logic [31:0] m_cyc, m_rd;

  function automatic logic [31:0] m_read(input logic [31:0] addr);
    logic [7:0] off;
    off = addr[7:0];
    if (addr[31:8] != BASE[31:8] || addr[1:0] != 2'b00) return 32'h0;
    if (off <= 8'h14) return {24'h0, m_seg[off / 4]};
    case (off)
      8'h18:   return {22'h0, m_led};
      8'h1C:   return {30'h0, m_deb};
      8'h20:   return {22'h0, m_sw2};
      8'h24:   return {30'h0, m_evt};
      8'h28:   return m_cyc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] mask, tmp, new_rd;
    logic [1:0]  clr, rise;
    logic [7:0]  off;
    if (Rst) begin
      for (int i = 0; i < 6; i++) m_seg[i] = 8'hFF;
      m_led = '0; m_hist1 = '0; m_hist2 = '0; m_deb = '0; m_deb_prev = '0;
      m_evt = '0; m_run[0] = 0; m_run[1] = 0; m_sw1 = '0; m_sw2 = '0;
      m_cyc = '0; m_rd = '0;
      return;
    end
    new_rd = SelDMemWb ? m_read(AluOut) : 32'h0;
    mask = {{8{CtrlDMemByteEn[3]}}, {8{CtrlDMemByteEn[2]}},
            {8{CtrlDMemByteEn[1]}}, {8{CtrlDMemByteEn[0]}}};
    clr = 2'b00;
    off = AluOut[7:0];
    if (CtrlDMemWrEn && AluOut[31:8] == BASE[31:8] && AluOut[1:0] == 2'b00) begin
      if (off <= 8'h14) begin
        tmp = ({24'h0, m_seg[off / 4]} & ~mask) | (RegRdData2 & mask);
        m_seg[off / 4] = tmp[7:0];
      end else if (off == 8'h18) begin
        tmp = ({22'h0, m_led} & ~mask) | (RegRdData2 & mask);
        m_led = tmp[9:0];
      end else if (off == 8'h24) begin
        tmp = RegRdData2 & mask;
        clr = tmp[1:0];
      end
    end
    rise       = m_deb & ~m_deb_prev;
    m_deb_prev = m_deb;
    m_evt      = (m_evt & ~clr) | rise;
    for (int b = 0; b < 2; b++) begin
      if (m_hist2[b] != m_deb[b]) begin
        m_run[b]++;
        if (m_run[b] == D) begin
          m_deb[b] = m_hist2[b];
          m_run[b] = 0;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    m_hist2 = m_hist1;
    m_hist1 = {Button_1, Button_0};
    m_sw2   = m_sw1;
    m_sw1   = Switch;
    m_cyc   = m_cyc + 32'd1;
    m_rd    = new_rd;
  endtask

  // One clock edge: advance the model, then compare all outputs after the edge.
  task automatic tick();
    if (CtrlDMemWrEn || SelDMemWb)
      $display("t=%0t rst=%b wr=%b rd=%b addr=%h data=%h be=%b", $time, Rst,
               CtrlDMemWrEn, SelDMemWb, AluOut, RegRdData2, CtrlDMemByteEn);
    @(posedge Clock);
    model_step();
    #1;
    check("led", {22'h0, LED}, {22'h0, m_led});
    for (int i = 0; i < 6; i++)
      check($sformatf("seg%0d", i), {24'h0, dut_seg[i]}, {24'h0, m_seg[i]});
    check("rdata", CrMemRdDataQ104H, m_rd);
  endtask

  task automatic bus(input logic we, input logic re, input logic [31:0] addr,
                     input logic [31:0] data, input logic [3:0] be);
    CtrlDMemWrEn   = we;
    SelDMemWb      = re;
    AluOut         = addr;
    RegRdData2     = data;
    CtrlDMemByteEn = be;
    tick();
    CtrlDMemWrEn = 1'b0;
    SelDMemWb    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int n_cyc;
  int hold0, hold1;

  initial begin
    // Reset state
    Rst = 1'b1;
    idle(2);
    check("rst_led", {22'h0, LED}, 32'h0);
    check("rst_seg0", {24'h0, SEG7_0}, 32'hFF);
    check("rst_seg5", {24'h0, SEG7_5}, 32'hFF);
    check("rst_rdata", CrMemRdDataQ104H, 32'h0);
    Rst = 1'b0;

    // Byte-enabled LED write and read-back
    bus(1, 0, BASE + 32'h18, 32'h1234_5603, 4'b0001);
    check("led_wr", {22'h0, LED}, 32'h3);
    bus(0, 1, BASE + 32'h18, 32'h0, 4'b0000);
    check("led_rd", CrMemRdDataQ104H, 32'h3);

    // SEG7_2 full-word write; RO and unaligned writes ignored
    bus(1, 0, BASE + 32'h08, 32'hAABB_CC40, 4'b1111);
    check("seg2_wr", {24'h0, SEG7_2}, 32'h40);
    check("seg1_keep", {24'h0, SEG7_1}, 32'hFF);
    bus(1, 0, BASE + 32'h20, 32'hFFFF_FFFF, 4'b1111);
    bus(1, 0, BASE + 32'h19, 32'hFFFF_FFFF, 4'b1111);
    bus(1, 0, BASE + 32'h40, 32'hFFFF_FFFF, 4'b1111);
    check("ro_led", {22'h0, LED}, 32'h3);
    check("ro_seg2", {24'h0, SEG7_2}, 32'h40);

    // Simultaneous write and read returns the pre-write value
    bus(1, 1, BASE + 32'h18, 32'hFFFF_FD55, 4'b0011);
    check("rw_rdata", CrMemRdDataQ104H, 32'h3);
    check("rw_led", {22'h0, LED}, 32'h155);

    // Switch synchronizer
    Switch = 10'h2A5;
    idle(3);
    bus(0, 1, BASE + 32'h20, 32'h0, 4'b0000);
    check("switch_rd", CrMemRdDataQ104H, 32'h2A5);

    // Bouncing Button_0, then held high: BTN reads back continuously
    for (int i = 0; i < 42; i++) begin
      Button_0 = ((i / 3) % 2) == 0;
      bus(0, 1, BASE + 32'h1C, 32'h0, 4'b0000);
    end
    Button_0 = 1'b1;
    for (int k = 1; k <= D + 4; k++) begin
      bus(0, 1, BASE + 32'h1C, 32'h0, 4'b0000);
      if (k == D + 2) check("btn0_before", {31'h0, CrMemRdDataQ104H[0]}, 32'h0);
      if (k == D + 3) check("btn0_rise", {31'h0, CrMemRdDataQ104H[0]}, 32'h1);
    end
    bus(0, 1, BASE + 32'h24, 32'h0, 4'b0000);
    check("evt_b0", CrMemRdDataQ104H, 32'h1);

    // Clear of bit 0 coincides with the Button_1 event being set
    Button_1 = 1'b1;
    for (int k = 1; k <= D + 3; k++) begin
      if (k == D + 3) bus(1, 0, BASE + 32'h24, 32'h0000_0001, 4'b0001);
      else            tick();
    end
    bus(0, 1, BASE + 32'h24, 32'h0, 4'b0000);
    check("evt_race", CrMemRdDataQ104H, 32'h2);
    bus(1, 0, BASE + 32'h24, 32'h0000_0002, 4'b0001);
    bus(0, 1, BASE + 32'h24, 32'h0, 4'b0000);
    check("evt_clr", CrMemRdDataQ104H, 32'h0);

    // Cycle counter after reset release; out-of-window read
    Button_0 = 1'b0;
    Button_1 = 1'b0;
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    n_cyc = $urandom_range(3, 20);
    idle(n_cyc);
    bus(0, 1, BASE + 32'h28, 32'h0, 4'b0000);
    check("cycle_rd", CrMemRdDataQ104H, 32'(n_cyc));
    bus(0, 1, 32'h00FD_0000, 32'h0, 4'b0000);
    check("miss_rd", CrMemRdDataQ104H, 32'h0);
    bus(0, 1, 32'h00FD_0028, 32'h0, 4'b0000);
    check("miss_rd2", CrMemRdDataQ104H, 32'h0);

    // Reset during a debounce count
    bus(1, 0, BASE + 32'h18, 32'h0000_03FF, 4'b0011);
    check("led_3ff", {22'h0, LED}, 32'h3FF);
    Button_0 = 1'b1;
    idle(12);
    Rst = 1'b1;
    bus(1, 0, BASE + 32'h00, 32'h0000_0000, 4'b0001);
    check("rst_mid_led", {22'h0, LED}, 32'h0);
    check("rst_mid_seg0", {24'h0, SEG7_0}, 32'hFF);
    Rst = 1'b0;
    for (int k = 1; k < D; k++) begin
      bus(0, 1, BASE + 32'h1C, 32'h0, 4'b0000);
      check("btn_hold", CrMemRdDataQ104H, 32'h0);
    end

    // Randomized traffic
    hold0 = 0;
    hold1 = 0;
    for (int c = 0; c < 3000; c++) begin
      int r;
      logic [31:0] addr;
      if (hold0 == 0) begin Button_0 = $urandom_range(0, 1); hold0 = $urandom_range(1, 40); end
      if (hold1 == 0) begin Button_1 = $urandom_range(0, 1); hold1 = $urandom_range(1, 40); end
      hold0--;
      hold1--;
      if (c % 5 == 0) Switch = 10'($urandom);
      r = $urandom_range(0, 99);
      if (r < 80)      addr = {BASE[31:8], 6'($urandom_range(0, 12)), 2'b00};
      else if (r < 90) addr = {BASE[31:8], 8'($urandom)};
      else             addr = $urandom;
      Rst = ($urandom_range(0, 299) == 0);
      bus($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 50, addr,
          $urandom, 4'($urandom));
    end
    Rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rvc_asap_5pl_cr_mem.md
RVC_ASAP_5PL_CR_MEM -- requirements
Module: rvc_asap_5pl_cr_mem

Interface
REQ-001 Parameter CR_BASE, 32'h00FC_0000, base address of the control-register window (256-byte window, address bits [7:0] are the offset).
REQ-002 Parameter DEBOUNCE_CYCLES, 16, number of consecutive stable cycles before a synchronized button level is accepted (range 2..65535).
REQ-003 Clock  input  1  single clock; every flop in the block is on its rising edge.
REQ-004 Rst  input  1  reset, synchronous and active-high.
REQ-005 AluOut  input  32  D_MEM byte address from the core, Q103H.
REQ-006 RegRdData2  input  32  D_MEM write data, Q103H.
REQ-007 CtrlDMemByteEn  input  4  write byte enables, Q103H; bit n enables byte n.
REQ-008 CtrlDMemWrEn  input  1  write request, Q103H.
REQ-009 SelDMemWb  input  1  read request, Q103H.
REQ-010 CrMemRdDataQ104H  output  32  read data, valid the cycle after the request.
REQ-011 Button_0, Button_1  input  1 each  raw asynchronous push-buttons, active-high after board inversion.
REQ-012 Switch  input  10  raw asynchronous slide switches.
REQ-013 SEG7_0..SEG7_5  output  8 each  seven-segment drive, active-low; bit 7 is the decimal point.
REQ-014 LED  output  10  LED drive, active-high.

Function
REQ-015 The block SHALL decode a hit when AluOut[31:8] == CR_BASE[31:8]; requests without a hit have no effect and read 0.
REQ-016 Register map (offset: access, width): 0x00-0x14 SEG7_0..SEG7_5 RW 8; 0x18 LED RW 10; 0x1C BTN RO 2 ({Button_1,Button_0} debounced); 0x20 SWITCH RO 10; 0x24 BTN_EVENT RW1C 2; 0x28 CYCLE RO 32.
REQ-017 Writes SHALL commit at the end of the request cycle, and only bytes whose CtrlDMemByteEn bit is set SHALL be written; unused upper bits are not stored and read 0.
REQ-018 Writes to RO offsets and unmapped offsets (0x2C-0xFC, non-word-aligned offsets) SHALL be ignored.
REQ-019 Read data SHALL be registered: CrMemRdDataQ104H equals the addressed register value sampled at the request cycle (before any same-cycle write), presented the next cycle.
REQ-020 CrMemRdDataQ104H SHALL be 0 the cycle after any cycle without a read hit.
REQ-021 Simultaneous CtrlDMemWrEn and SelDMemWb: the write SHALL be performed and the read SHALL return the pre-write value.
REQ-022 Each button and each Switch bit SHALL pass a 2-flop synchronizer before any other use.
REQ-023 Button debounce: a per-button counter SHALL reset to 0 whenever the synchronized level equals the debounced level and SHALL otherwise increment; when it reaches DEBOUNCE_CYCLES-1 the debounced level SHALL take the synchronized level and the counter SHALL clear.
REQ-024 Switch values SHALL be synchronized only (no debounce).
REQ-025 A 0->1 transition of a debounced button SHALL set its BTN_EVENT bit the following cycle.
REQ-026 Writing 1 to a BTN_EVENT bit SHALL clear it; writing 0 SHALL have no effect; a set event in the same cycle as a clear SHALL win (bit stays 1).
REQ-027 CYCLE SHALL increment by 1 every cycle and wrap from 32'hFFFF_FFFF to 0.
REQ-028 SEG7_n and LED outputs SHALL be driven directly from their registers (no combinational path from inputs).
REQ-029 Button-to-BTN latency SHALL be 2 sync cycles + DEBOUNCE_CYCLES cycles, maximum.

Reset
REQ-030 On Rst high at a rising edge: SEG7_0..5 = 8'hFF, LED = 0, BTN debounced = 0, debounce counters = 0, synchronizers = 0, BTN_EVENT = 0, CYCLE = 0, CrMemRdDataQ104H = 0.
REQ-031 Reset asserted mid-debounce or mid-request SHALL discard the in-progress count and request; no write commits in a reset cycle.

Verification
REQ-032 Write 32'h1234_5603 to 0x00FC_0018, byte-enable 4'b0001 -> LED = 10'h003; read 0x18 -> 32'h0000_0003 one cycle later.
REQ-033 Write 32'hAABB_CC40 to 0x00FC_0008, byte-enable 4'b1111 -> SEG7_2 = 8'h40, other SEG7 stay 8'hFF; write to 0x00FC_0020 -> no register changes.
REQ-034 Button_0 bounces 1/0 every 3 cycles for 40 cycles, then held high -> BTN bit0 rises exactly DEBOUNCE_CYCLES+2 cycles after the final edge; BTN_EVENT = 2'b01.
REQ-035 Write 2'b01 to BTN_EVENT in the same cycle as a Button_1 debounced rising edge -> BTN_EVENT = 2'b10.
REQ-036 Read 0x00FC_0028 at cycle N after reset release -> CrMemRdDataQ104H = N; read to 0x00FD_0000 -> 0.
REQ-037 Assert Rst with LED = 10'h3FF and a counter at 10 -> next cycle LED = 0 and BTN unchanged at 0 after release for DEBOUNCE_CYCLES-1 stable cycles.
